// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int DEF_LINES          = 16;
  localparam int DEF_WORDS_PER_LINE = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FLUSH  = 2'd3
  } state_e;

endpackage

// File: rtl/dcache_if.sv
// CPU-side and backing-memory-side signals of the data cache, bundled as one interface.
interface dcache_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // The cache itself uses the slave view; CPU and memory models use the master view.
  modport slave (
    input  req, we, addr, wdata, flush, mem_ack, mem_rdata,
    output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, flush, mem_ack, mem_rdata,
    input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ram.sv
// Cache data store: one synchronous write port, one asynchronous read port, no reset.
module dcache_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with in-order line refill.
module dcache
  import dcache_pkg::*;
#(
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic     clk,
  input  logic     reset,
  dcache_if.slave  bus
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
  localparam logic [1:0] S_REFILL = 2'(ST_REFILL);
  localparam logic [1:0] S_WRITE  = 2'(ST_WRITE);
  localparam logic [1:0] S_FLUSH  = 2'(ST_FLUSH);

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             unused_addr_bits;

  assign off = bus.addr[OFF_W+1:2];
  assign idx = bus.addr[OFF_W+IDX_W+1:OFF_W+2];
  assign tag = bus.addr[31:OFF_W+IDX_W+2];
  assign unused_addr_bits = ^bus.addr[1:0];

  logic [1:0]       state_q, state_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_mem [LINES];

  logic                   tag_we, hit;
  logic                   ram_we;
  logic [IDX_W+OFF_W-1:0] ram_waddr;
  logic [31:0]            ram_wdata, ram_rdata;

  logic        stall_c, mem_req_c, mem_we_c;
  logic [31:0] rdata_c, mem_addr_c, mem_wdata_c;

  assign hit = valid_q[idx] && (tag_mem[idx] == tag);

  dcache_ram #(
    .DEPTH (LINES * WORDS_PER_LINE),
    .AW    (IDX_W + OFF_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr ({idx, off}),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    valid_d     = valid_q;
    tag_we      = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = {idx, off};
    ram_wdata   = bus.wdata;
    stall_c     = 1'b0;
    rdata_c     = '0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.flush) begin
          state_d = S_FLUSH;
          stall_c = bus.req;
        end else if (bus.req && !bus.we) begin
          if (hit) begin
            rdata_c = ram_rdata;
          end else begin
            // Drop the line's valid bit now so an interrupted refill can never be hit.
            stall_c      = 1'b1;
            state_d      = S_REFILL;
            beat_d       = '0;
            valid_d[idx] = 1'b0;
          end
        end else if (bus.req) begin
          stall_c = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_REFILL: begin
        mem_req_c  = 1'b1;
        mem_addr_c = {tag, idx, beat_q, 2'b00};
        stall_c    = bus.req;
        ram_waddr  = {idx, beat_q};
        ram_wdata  = bus.mem_rdata;
        if (bus.mem_ack) begin
          ram_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (&beat_q) begin
            tag_we       = 1'b1;
            valid_d[idx] = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        mem_req_c   = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = {bus.addr[31:2], 2'b00};
        mem_wdata_c = bus.wdata;
        stall_c     = bus.req && !bus.mem_ack;
        if (bus.mem_ack) begin
          ram_we  = hit;
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        valid_d = '0;
        state_d = S_IDLE;
        stall_c = bus.req;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) tag_mem[idx] <= tag;
  end

  // Reset is asynchronous, so outputs are forced quiet for as long as it is held.
  assign bus.stall     = reset & stall_c;
  assign bus.rdata     = reset ? rdata_c : '0;
  assign bus.mem_req   = reset & mem_req_c;
  assign bus.mem_we    = reset & mem_we_c;
  assign bus.mem_addr  = reset ? mem_addr_c : '0;
  assign bus.mem_wdata = reset ? mem_wdata_c : '0;

endmodule

// File: tb/tb_dcache.sv
// Randomized scoreboard bench for dcache against a line-level cache model and a word memory model.
module tb_dcache;

  localparam int LINES      = 16;
  localparam int WPL        = 4;
  localparam int LINE_BYTES = WPL * 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dcache_if bus_i ();

  dcache #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_i)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    bit          exp_hit;
    int          exp_stall;
  } exp_t;

  exp_t sb[$];
  int tests = 0, fails = 0, done_cnt = 0, stall_cnt = 0, beat_cnt = 0;
  int fixed_wait = 0, wait_max = 3, wcnt = -1;

  logic [31:0] bmem    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  bit          m_valid [LINES];
  logic [31:0] m_line  [LINES];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return ref_mem.exists(w) ? ref_mem[w] : w;
  endfunction

  function automatic void m_flush();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endfunction

  // Backing memory: unwritten words read back as their own address.
  always @(posedge clk) begin
    #2;
    if (!reset || !bus_i.mem_req) begin
      bus_i.mem_ack = 1'b0;
      wcnt = -1;
    end else begin
      if (wcnt < 0) wcnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(wait_max, 0));
      if (wcnt == 0) begin
        bus_i.mem_ack = 1'b1;
        if (bus_i.mem_we) bmem[bus_i.mem_addr] = bus_i.mem_wdata;
        else bus_i.mem_rdata = bmem.exists(bus_i.mem_addr) ? bmem[bus_i.mem_addr] : bus_i.mem_addr;
        wcnt = -1;
      end else begin
        bus_i.mem_ack = 1'b0;
        wcnt--;
      end
    end
  end

  // Monitor: checks memory beats as they complete and pops the scoreboard when stall drops.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      stall_cnt = 0;
      beat_cnt  = 0;
    end else begin
      if (bus_i.mem_req && bus_i.mem_ack) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL mem_beat_without_access: addr 0x%08h, expected no memory traffic", bus_i.mem_addr);
        end else if (sb[0].we) begin
          chk("store_mem_we", 32'(bus_i.mem_we), 32'd1);
          chk("store_mem_addr", bus_i.mem_addr, {sb[0].addr[31:2], 2'b00});
          chk("store_mem_wdata", bus_i.mem_wdata, sb[0].data);
        end else begin
          chk("refill_mem_we", 32'(bus_i.mem_we), 32'd0);
          chk("refill_mem_addr", bus_i.mem_addr,
              (sb[0].addr & ~32'(LINE_BYTES - 1)) + 32'(beat_cnt * 4));
          beat_cnt++;
        end
      end
      if (!bus_i.req) begin
        chk("stall_without_req", 32'(bus_i.stall), 32'd0);
      end else if (bus_i.stall) begin
        stall_cnt++;
      end else if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_completion: addr 0x%08h, expected none", bus_i.addr);
      end else begin
        e = sb.pop_front();
        if (!e.we) begin
          chk("load_rdata", bus_i.rdata, e.data);
          chk("load_refill_beats", 32'(beat_cnt), e.exp_hit ? 32'd0 : 32'(WPL));
        end
        if (e.exp_stall >= 0) chk("stall_cycles", 32'(stall_cnt), 32'(e.exp_stall));
        $display("[TB] %s addr=0x%08h data=0x%08h hit=%0d stalls=%0d",
                 e.we ? "ST" : "LD", e.addr, e.we ? e.data : bus_i.rdata, e.exp_hit, stall_cnt);
        stall_cnt = 0;
        beat_cnt  = 0;
        done_cnt++;
      end
    end
  end

  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d, input bit fl);
    exp_t e;
    int target;
    bit ok;
    logic [31:0] ln;
    int slot;
    if (fl) m_flush();
    ln   = a / 32'(LINE_BYTES);
    slot = int'(ln % 32'(LINES));
    e.we      = w;
    e.addr    = a;
    e.exp_hit = m_valid[slot] && (m_line[slot] == ln);
    if (w) begin
      ref_mem[{a[31:2], 2'b00}] = d;
      e.data = d;
    end else begin
      e.data = ref_read(a);
      m_valid[slot] = 1'b1;
      m_line[slot]  = ln;
    end
    if (fixed_wait < 0)  e.exp_stall = -1;
    else if (w)          e.exp_stall = 1 + fixed_wait;
    else if (e.exp_hit)  e.exp_stall = 0;
    else                 e.exp_stall = 1 + WPL * (fixed_wait + 1);
    if (fl && e.exp_stall >= 0) e.exp_stall += 2;
    target = done_cnt + 1;
    sb.push_back(e);
    bus_i.req   = 1'b1;
    bus_i.we    = w;
    bus_i.addr  = a;
    bus_i.wdata = d;
    bus_i.flush = fl;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      bus_i.flush = 1'b0;
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("access_timeout", 32'(ok), 32'd1);
      sb.delete();
      bus_i.req = 1'b0;
    end
  endtask

  task automatic idle(input int n, input bit fl);
    bus_i.req   = 1'b0;
    bus_i.flush = fl;
    if (fl) m_flush();
    repeat (n) begin
      @(posedge clk);
      #1;
      bus_i.flush = 1'b0;
    end
  endtask

  // Abandon a refill after three beats by asserting reset, then check the line was discarded.
  task automatic mid_refill_reset();
    exp_t e;
    e.we = 1'b0;
    e.addr = 32'h80;
    e.data = ref_read(32'h80);
    e.exp_hit = 1'b0;
    e.exp_stall = -1;
    sb.push_back(e);
    bus_i.req  = 1'b1;
    bus_i.we   = 1'b0;
    bus_i.addr = 32'h80;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    m_flush();
    #1;
    chk("midreset_mem_req", 32'(bus_i.mem_req), 32'd0);
    chk("midreset_stall", 32'(bus_i.stall), 32'd0);
    chk("midreset_rdata", bus_i.rdata, 32'd0);
    @(posedge clk);
    #1;
    bus_i.req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    bit w, fl;
    bus_i.req   = 1'b1;
    bus_i.we    = 1'b0;
    bus_i.addr  = 32'h40;
    bus_i.wdata = 32'h0;
    bus_i.flush = 1'b0;
    m_flush();
    #3;
    chk("reset_stall", 32'(bus_i.stall), 32'd0);
    chk("reset_mem_req", 32'(bus_i.mem_req), 32'd0);
    chk("reset_mem_we", 32'(bus_i.mem_we), 32'd0);
    chk("reset_mem_addr", bus_i.mem_addr, 32'd0);
    chk("reset_mem_wdata", bus_i.mem_wdata, 32'd0);
    chk("reset_rdata", bus_i.rdata, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus_i.req = 1'b0;
    reset = 1'b1;
    idle(1, 1'b0);

    fixed_wait = 0;
    access(1'b0, 32'h40, 32'h0, 1'b0);
    access(1'b0, 32'h48, 32'h0, 1'b0);
    fixed_wait = 2;
    access(1'b1, 32'h44, 32'hDEADBEEF, 1'b0);
    fixed_wait = 0;
    access(1'b0, 32'h44, 32'h0, 1'b0);
    access(1'b1, 32'h400, 32'h12345678, 1'b0);
    access(1'b0, 32'h400, 32'h0, 1'b0);
    access(1'b0, 32'h40, 32'h0, 1'b1);
    idle(1, 1'b0);
    mid_refill_reset();
    access(1'b0, 32'h80, 32'h0, 1'b0);

    fixed_wait = -1;
    for (int i = 0; i < 300; i++) begin
      a = (32'($urandom_range(3, 0)) << 8) | (32'($urandom_range(63, 0)) << 2);
      if ($urandom_range(7, 0) == 0) a[31] = 1'b1;
      w  = ($urandom_range(9, 0) < 3);
      fl = ($urandom_range(15, 0) == 0);
      access(w, a, $urandom, fl);
      if ($urandom_range(7, 0) == 0) idle(int'($urandom_range(3, 1)), $urandom_range(3, 0) == 0);
    end
    idle(2, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
